// File: rtl/seg_display_driver_pkg.sv
// Shared constants and helpers for the two-digit 7-segment display driver.
// Holds the segment codes, the converter FSM encoding and the double-dabble step.
package seg_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One double-dabble iteration on {hundreds, tens, units, binary}.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int n = 0; n < 3; n++) begin
      if (adj[8+4*n +: 4] >= 4'd5) adj[8+4*n +: 4] = adj[8+4*n +: 4] + 4'd3;
    end
    return {adj[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Board-facing bundle of the display driver: value in, segment/digit drive and status out.
interface seg_display_driver_if;
  logic [7:0] num_in;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       disp_ok;
  logic       busy;

  modport master (output num_in, input seg, input dig_sel, input disp_ok, input busy);
  modport slave  (input num_in, output seg, output dig_sel, output disp_ok, output busy);
endinterface

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// done pulses for the single COMMIT cycle while bcd holds the finished result.
module seg_display_driver_bin2bcd_seq
  import seg_display_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [19:0] shreg_q, shreg_d;
  logic [2:0]  i_q, i_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    i_d     = i_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          shreg_d = {12'h000, bin};
          i_d     = 3'd0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        shreg_d = dd_step(shreg_q);
        i_d     = i_q + 3'd1;
        if (i_q == 3'd7) begin
          state_d = COMMIT;
          done_d  = 1'b1;
        end
      end
      COMMIT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = shreg_q[19:8];

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed 7-segment driver for the countdown value: change detection,
// display registers, digit scan and registered segment/digit-enable outputs.
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int SCAN_DIV       = 50,
  parameter bit BLANK_LEAD     = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  seg_display_driver_if.slave bus
);

  localparam int                CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]        DIG_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  function automatic logic [6:0] pol7(input logic [6:0] x);
    return SEG_ACTIVE_LOW ? ~x : x;
  endfunction

  function automatic logic [1:0] pol2(input logic [1:0] x);
    return SEG_ACTIVE_LOW ? ~x : x;
  endfunction

  logic [7:0]       last_cap_q, last_cap_d;
  logic             pending_q, pending_d;
  logic [3:0]       hund_q, hund_d, tens_q, tens_d, units_q, units_d;
  logic             disp_ok_q, disp_ok_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             phase_q, phase_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dig_sel_q, dig_sel_d;

  logic             start, conv_busy, conv_done;
  logic [11:0]      conv_bcd;
  logic             over_range;
  logic [6:0]       units_pat, tens_pat;

  assign start = !conv_busy && ((bus.num_in != last_cap_q) || pending_q);

  seg_display_driver_bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bus.num_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    last_cap_d = last_cap_q;
    pending_d  = pending_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    units_d    = units_q;
    disp_ok_d  = disp_ok_q;
    scan_cnt_d = scan_cnt_q;
    phase_d    = phase_q;

    if (start) begin
      last_cap_d = bus.num_in;
      pending_d  = 1'b0;
    end
    if (conv_done) begin
      hund_d    = conv_bcd[11:8];
      tens_d    = conv_bcd[7:4];
      units_d   = conv_bcd[3:0];
      disp_ok_d = 1'b1;
    end

    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d = '0;
      phase_d    = ~phase_q;
    end else begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
    end

    // Any nonzero hundreds digit means the value is above 99 and shows as "--".
    over_range = (hund_q != 4'd0);
    units_pat  = over_range ? SEG_DASH : seg_decode(units_q);
    tens_pat   = over_range ? SEG_DASH :
                 (BLANK_LEAD && (tens_q == 4'd0)) ? SEG_BLANK : seg_decode(tens_q);

    if (!disp_ok_q) begin
      seg_d     = SEG_OFF;
      dig_sel_d = DIG_OFF;
    end else if (phase_q) begin
      seg_d     = pol7(tens_pat);
      dig_sel_d = pol2(2'b10);
    end else begin
      seg_d     = pol7(units_pat);
      dig_sel_d = pol2(2'b01);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cap_q <= 8'h00;
      pending_q  <= 1'b1;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      disp_ok_q  <= 1'b0;
      scan_cnt_q <= '0;
      phase_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_sel_q  <= DIG_OFF;
    end else begin
      last_cap_q <= last_cap_d;
      pending_q  <= pending_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      disp_ok_q  <= disp_ok_d;
      scan_cnt_q <= scan_cnt_d;
      phase_q    <= phase_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.dig_sel = dig_sel_q;
  assign bus.disp_ok = disp_ok_q;
  assign bus.busy    = conv_busy;

endmodule
